// File: rtl/tan_req_scheduler.sv
// Round-robin scheduler sharing one tangent core among NREQ requesters.
// Drives the core's start/ready/busy handshake, returns results with a one-cycle ack, and aborts hung transactions.
module tan_req_scheduler #(
    parameter int NREQ = 4,
    parameter int XW   = 16,
    parameter int TW   = 16,
    parameter int TMO  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*XW-1:0]   x_in,
    output logic [NREQ-1:0]      ack,
    output logic [TW-1:0]        res_tan,
    output logic                 res_err,
    output logic [2:0]           grant_id,
    output logic                 sched_busy,
    output logic                 calc_start,
    output logic [XW-1:0]        calc_x,
    input  logic                 calc_ready,
    input  logic                 calc_busy,
    input  logic [TW-1:0]        calc_tan
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TMO - 1);

    state_t          state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      gid_q, gid_d;
    logic [XW-1:0]   x_q, x_d;
    logic [TW-1:0]   tan_q, tan_d;
    logic            err_q, err_d;
    logic [15:0]     wd_q, wd_d;
    logic            seen_ready_q, seen_ready_d;

    logic [XW-1:0]   x_ext [8];
    logic            found;
    logic [2:0]      win;
    logic [3:0]      rr_inc;
    logic            wd_expired;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_xsel
            if (gi < NREQ) begin : g_used
                assign x_ext[gi] = x_in[gi*XW +: XW];
            end else begin : g_pad
                assign x_ext[gi] = '0;
            end
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = (state_q == S_DONE) && (gid_q == 3'(gi));
        end
    endgenerate

    // Two passes: indices at or above rr first, then wrap to the low indices.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (3'(i) >= rr_q)) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
    end

    assign rr_inc     = {1'b0, gid_q} + 4'd1;
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gid_d        = gid_q;
        x_d          = x_q;
        tan_d        = tan_q;
        err_d        = err_q;
        wd_d         = wd_q;
        seen_ready_d = seen_ready_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gid_d        = win;
                    x_d          = x_ext[win];
                    wd_d         = '0;
                    seen_ready_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Exit only on a ready 1->0 edge seen while start is held.
                wd_d = wd_q + 16'd1;
                if (calc_ready) begin
                    seen_ready_d = 1'b1;
                end
                if (!calc_ready && seen_ready_q) begin
                    wd_d    = '0;
                    state_d = S_RELEASE;
                end else if (wd_expired) begin
                    wd_d    = '0;
                    tan_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RELEASE: begin
                wd_d = wd_q + 16'd1;
                if (calc_busy) begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end else if (wd_expired) begin
                    wd_d    = '0;
                    tan_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 16'd1;
                if (calc_ready) begin
                    wd_d    = '0;
                    tan_d   = calc_tan;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    wd_d    = '0;
                    tan_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wd_d    = '0;
                rr_d    = (rr_inc >= 4'(NREQ)) ? 3'd0 : rr_inc[2:0];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            gid_q        <= '0;
            x_q          <= '0;
            tan_q        <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            seen_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gid_q        <= gid_d;
            x_q          <= x_d;
            tan_q        <= tan_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            seen_ready_q <= seen_ready_d;
        end
    end

    assign calc_start = (state_q == S_ISSUE);
    assign sched_busy = (state_q != S_IDLE);
    assign grant_id   = gid_q;
    assign calc_x     = x_q;
    assign res_tan    = tan_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_tan_req_scheduler.sv
// Directed bench for tan_req_scheduler with a behavioural tangent-core model (result = x + 5, 12-cycle compute).
module tb_tan_req_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [63:0]  x_in;
    logic [3:0]   ack;
    logic [15:0]  res_tan;
    logic         res_err;
    logic [2:0]   grant_id;
    logic         sched_busy;
    logic         calc_start;
    logic [15:0]  calc_x;

    logic         core_ready = 1'b1;
    logic         core_busy  = 1'b0;
    logic [15:0]  core_tan   = 16'h0000;
    logic [1:0]   core_st    = 2'd0;
    logic [4:0]   core_cnt   = 5'd0;
    logic [15:0]  core_x     = 16'h0000;
    logic         hung;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tan_req_scheduler #(.NREQ(4), .XW(16), .TW(16), .TMO(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .x_in       (x_in),
        .ack        (ack),
        .res_tan    (res_tan),
        .res_err    (res_err),
        .grant_id   (grant_id),
        .sched_busy (sched_busy),
        .calc_start (calc_start),
        .calc_x     (calc_x),
        .calc_ready (core_ready),
        .calc_busy  (core_busy),
        .calc_tan   (core_tan)
    );

    // Core model: ready drops the cycle after start is seen, busy rises the cycle after start falls.
    always @(posedge clk) begin
        case (core_st)
            2'd0: if (calc_start && !hung) begin
                core_st    <= 2'd1;
                core_ready <= 1'b0;
                core_x     <= calc_x;
            end
            2'd1: if (!calc_start) begin
                core_st   <= 2'd2;
                core_busy <= 1'b1;
                core_cnt  <= 5'd12;
            end
            default: begin
                if (core_cnt == 5'd1) begin
                    core_st    <= 2'd0;
                    core_busy  <= 1'b0;
                    core_ready <= 1'b1;
                    core_tan   <= core_x + 16'd5;
                end else begin
                    core_cnt <= core_cnt - 5'd1;
                end
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for one ack and checks the whole transaction; exp_lat/exp_starts < 0 skip those checks.
    task automatic serve(input string tag, input int idx, input logic [15:0] exp_tan,
                         input logic exp_err, input int exp_lat, input int exp_starts,
                         input logic scramble, input logic [15:0] xexp, input logic drop);
        int cyc;
        int starts;
        int xbad;
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << idx;
        cyc = 0;
        starts = 0;
        xbad = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (calc_start) starts++;
            if (sched_busy && calc_x !== xexp) xbad++;
            if (scramble) x_in[32 +: 16] = 16'($urandom);
        end while (ack == 4'b0000 && cyc < 300);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_gid"}, 32'(grant_id), 32'(idx));
        chk({tag, "_tan"}, 32'(res_tan), 32'(exp_tan));
        chk({tag, "_err"}, 32'(res_err), 32'(exp_err));
        chk({tag, "_start_at_ack"}, 32'(calc_start), 32'd0);
        chk({tag, "_x_stable"}, 32'(xbad), 32'd0);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        if (exp_starts >= 0) chk({tag, "_start_cycles"}, 32'(starts), 32'(exp_starts));
        if (drop) req[idx] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ack_one_cycle"}, 32'(ack), 32'd0);
        $display("%s: ack=%b gid=%0d tan=%h err=%0d latency=%0d start_cycles=%0d",
                 tag, exp_ack, idx, res_tan, res_err, cyc, starts);
    endtask

    logic [15:0] t2_res [4];

    initial begin
        int n;
        t2_res = '{16'h1116, 16'h2227, 16'h3338, 16'h4449};
        rst  = 1'b0;
        req  = 4'b0000;
        x_in = 64'h0;
        hung = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_start", 32'(calc_start), 32'd0);
        chk("rst_busy", 32'(sched_busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_tan", 32'(res_tan), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_calc_x", 32'(calc_x), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request on requester 0
        x_in[0 +: 16] = 16'h0100;
        req = 4'b0001;
        serve("t1_single", 0, 16'h0105, 1'b0, 17, 2, 1'b0, 16'h0100, 1'b1);

        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_tan", 32'(res_tan), 32'd0);
        rst = 1'b1;

        // Contention: all four pending, each drops after its ack
        x_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("t2_rr%0d", i), i, t2_res[i], 1'b0, 17, 2, 1'b0, x_in[i*16 +: 16], 1'b1);
        end
        req[0] = 1'b1;
        serve("t2_again0", 0, 16'h1116, 1'b0, 17, 2, 1'b0, 16'h1111, 1'b1);

        // Operand stability while x_in[2] is scrambled every cycle
        x_in[32 +: 16] = 16'h3000;
        req = 4'b0100;
        serve("t3_stable", 2, 16'h3005, 1'b0, 17, 2, 1'b1, 16'h3000, 1'b1);

        // Hung core: ready never drops
        hung = 1'b1;
        x_in[0 +: 16] = 16'h0abc;
        req = 4'b0001;
        serve("t4_hung", 0, 16'h0000, 1'b1, 21, 20, 1'b0, 16'h0abc, 1'b1);
        hung = 1'b0;
        x_in[16 +: 16] = 16'h0200;
        req = 4'b0010;
        serve("t4_recover", 1, 16'h0205, 1'b0, 17, 2, 1'b0, 16'h0200, 1'b1);

        // Reset in the middle of WAIT
        x_in[48 +: 16] = 16'h7000;
        req = 4'b1000;
        n = 0;
        while (!core_busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_wait", 32'(n < 50), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_in_wait", 32'(sched_busy && !calc_start), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rst_ack", 32'(ack), 32'd0);
        chk("t5_rst_start", 32'(calc_start), 32'd0);
        chk("t5_rst_busy", 32'(sched_busy), 32'd0);
        chk("t5_rst_gid", 32'(grant_id), 32'd0);
        chk("t5_rst_tan", 32'(res_tan), 32'd0);
        rst = 1'b1;
        x_in[0 +: 16]  = 16'h0011;
        x_in[32 +: 16] = 16'h0022;
        req = 4'b0101;
        serve("t5_after_rst", 0, 16'h0016, 1'b0, -1, -1, 1'b0, 16'h0011, 1'b1);
        serve("t5_idx2", 2, 16'h0027, 1'b0, 17, 2, 1'b0, 16'h0022, 1'b1);

        // Back-to-back: requester 1 keeps req high, requester 3 arrives meanwhile
        x_in[16 +: 16] = 16'h0600;
        x_in[48 +: 16] = 16'h0800;
        req = 4'b0010;
        serve("t6_first1", 1, 16'h0605, 1'b0, 17, 2, 1'b0, 16'h0600, 1'b0);
        req[3] = 1'b1;
        serve("t6_other3", 3, 16'h0805, 1'b0, 17, 2, 1'b0, 16'h0800, 1'b1);
        serve("t6_second1", 1, 16'h0605, 1'b0, 17, 2, 1'b0, 16'h0600, 1'b1);
        req = 4'b0101;
        serve("t6_rr_is2", 2, 16'h0027, 1'b0, 17, 2, 1'b0, 16'h0022, 1'b1);
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tan_req_scheduler.md
Name: tan_req_scheduler

Overview:
- Shares one tangent-calculator core among NREQ requesters using round-robin arbitration.
- Latches the granted requester's operand and drives the core's start/ready/busy handshake: start is held high until the core leaves idle, then released.
- Captures the core's result and returns it to the requester with a one-cycle ack.
- Sits between the client blocks and the tangent core. A watchdog aborts a hung transaction.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XW, 16, operand width.
- TW, 16, result width.
- TMO, 255, watchdog limit in cycles per wait state (1..65535).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- req  in  NREQ  per-requester level request, held until ack.
- x_in  in  NREQ*XW  packed operands; slice i = bits [i*XW +: XW].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- res_tan  out  TW  result, valid in the ack cycle, held until the next ack.
- res_err  out  1  timeout flag, valid with ack, held until the next ack.
- grant_id  out  3  index of the requester in service.
- sched_busy  out  1  high in every state except IDLE.
- calc_start  out  1  start to the core.
- calc_x  out  XW  operand to the core.
- calc_ready  in  1  core idle/ready.
- calc_busy  in  1  core computing.
- calc_tan  in  TW  core result.

Behaviour:
Reset (rst==0 at a clk edge, whatever the state):
- state=IDLE.
- ack=0, calc_start=0, calc_x=0, res_tan=0, res_err=0, grant_id=0, sched_busy=0.
- Round-robin pointer rr=0; watchdog count wd=0.
- Reset mid-transaction drops the transaction; no ack is issued.

Arbitration (IDLE only):
- Search starts at index rr and wraps modulo NREQ; the first i with req[i]=1 wins.
- On grant: grant_id<=i, calc_x<=x_in slice i, state<=ISSUE.
- rr<=(i+1) mod NREQ, updated at ack.
- req changes outside IDLE do not affect the transaction in service.

States:
- IDLE: outputs quiescent. Grant on any req.
- ISSUE: calc_start=1. Go to RELEASE when calc_ready==0, meaning the core has left idle.
- RELEASE: calc_start=0. Go to WAIT when calc_busy==1.
- WAIT: calc_start=0. When calc_ready==1: res_tan<=calc_tan, res_err<=0, go to DONE.
- DONE: ack[grant_id]=1 for exactly this cycle, then go to IDLE.

calc_x:
- Stable from ISSUE through DONE.
- Retains its last value in IDLE.

Watchdog:
- wd clears on every state entry and increments each cycle spent in ISSUE, RELEASE or WAIT.
- If wd reaches TMO: calc_start<=0, res_err<=1, res_tan<=0, go to DONE. The ack is still issued.

Latency and timing:
- Minimum req-to-ack latency = 1 (grant) + ISSUE + RELEASE + WAIT + DONE cycles, set by the core's response.
- Nominal core: ISSUE 1 cycle, RELEASE 1, WAIT = core compute length.
- Back-to-back: the earliest next grant is the cycle after DONE, because IDLE takes one cycle.

Requester contract:
- The requester drops req in the cycle after ack.
- If req is still 1 in IDLE, it is a new request.
- rr guarantees another pending requester wins first.

Boundary conditions:
- If calc_ready is already 0 on entering ISSUE (core not idle), ISSUE waits there until calc_ready==1 then 0. The ISSUE exit condition is a calc_ready 1-to-0 transition observed while start is high; ISSUE tracks one bit of history to detect it.
- calc_ready and calc_busy both high in WAIT: treat as done.
- All req low: remain in IDLE; rr unchanged.
- NREQ=1: rr stays 0.

Test Plan:
1. Single request: req=0001, x_in[0]=16'h0100; core model ready drops 1 cycle after start, busy 1 cycle after release, computes 12 cycles, returns 16'h0105 -> ack=0001 exactly one cycle, res_tan=16'h0105, res_err=0, calc_start high exactly until ready drops.
2. Contention: req=1111 held, each requester dropping req after its ack -> ack order 0,1,2,3, then 0 again if req[0] is re-raised. No requester is granted twice while another is pending.
3. Operand stability: change x_in[2] every cycle after grant of requester 2 -> calc_x equals the value latched at grant for the whole transaction.
4. Hung core: calc_ready stuck 1 after start, TMO=20 -> ack after 20 cycles in ISSUE, res_err=1, res_tan=0, calc_start=0. The next request is served normally.
5. Reset mid-WAIT: assert rst=0 for 1 cycle -> next cycle ack=0, calc_start=0, sched_busy=0, rr=0. A subsequent req=0100 is granted to index 2.
6. Back-to-back same requester: req[1] held high through ack -> second grant to 1 only when no other req is pending. rr after ack = 2.
